// File: rtl/seg7_scan4.sv
// rtl/seg7_scan4.sv - four-digit multiplexed 7-segment scanner with frame-aligned value swap
module seg7_scan4 #(
    parameter int DIV_WIDTH    = 16,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_value,
    input  logic [3:0]  in_dp,
    input  logic        in_lzb,
    output logic [7:0]  seg_out,
    output logic [3:0]  digit_sel,
    output logic        frame_done
);

    localparam logic [DIV_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [DIV_WIDTH-1:0] CNT_ONE   = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] BLANK_LIM = DIV_WIDTH'(BLANK_CYCLES);

    logic [DIV_WIDTH-1:0] cnt;
    logic [1:0]           idx;
    logic [15:0]          disp_value;
    logic [3:0]           disp_dp;
    logic                 disp_lzb;
    logic [15:0]          pend_value;
    logic [3:0]           pend_dp;
    logic                 pend_lzb;
    logic                 pend_full;

    logic [DIV_WIDTH-1:0] cnt_n;
    logic [1:0]           idx_n;
    logic [15:0]          disp_value_n;
    logic [3:0]           disp_dp_n;
    logic                 disp_lzb_n;
    logic                 pend_full_n;
    logic                 boundary;
    logic                 accept;
    logic [3:0]           nib_n;
    logic                 lead_zero_n;
    logic [7:0]           seg_n;
    logic [3:0]           sel_n;
    logic                 done_n;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b1110010;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Outputs are registered from next-state values so they line up with the cycle cnt/idx describe.
    always_comb begin
        boundary     = (cnt == CNT_MAX) && (idx == 2'd3);
        accept       = in_valid && !pend_full;
        cnt_n        = cnt + CNT_ONE;
        idx_n        = (cnt == CNT_MAX) ? idx + 2'd1 : idx;
        disp_value_n = disp_value;
        disp_dp_n    = disp_dp;
        disp_lzb_n   = disp_lzb;
        pend_full_n  = pend_full;
        if (boundary && pend_full) begin
            disp_value_n = pend_value;
            disp_dp_n    = pend_dp;
            disp_lzb_n   = pend_lzb;
            pend_full_n  = 1'b0;
        end
        if (accept) begin
            pend_full_n = 1'b1;
        end

        nib_n = disp_value_n[{idx_n, 2'b00} +: 4];
        case (idx_n)
            2'd3:    lead_zero_n = (disp_value_n[15:12] == 4'h0);
            2'd2:    lead_zero_n = (disp_value_n[15:8] == 8'h00);
            2'd1:    lead_zero_n = (disp_value_n[15:4] == 12'h000);
            default: lead_zero_n = 1'b0;
        endcase

        if (cnt_n < BLANK_LIM) begin
            seg_n = 8'hFF;
            sel_n = 4'hF;
        end else begin
            seg_n = {(disp_lzb_n && lead_zero_n) ? 7'h7F : decode(nib_n), !disp_dp_n[idx_n]};
            sel_n = ~(4'b0001 << idx_n);
        end
        done_n = (cnt_n == CNT_MAX) && (idx_n == 2'd3);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= 2'd0;
            disp_value <= 16'h0000;
            disp_dp    <= 4'h0;
            disp_lzb   <= 1'b0;
            pend_value <= 16'h0000;
            pend_dp    <= 4'h0;
            pend_lzb   <= 1'b0;
            pend_full  <= 1'b0;
            in_ready   <= 1'b1;
            seg_out    <= 8'hFF;
            digit_sel  <= 4'hF;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_n;
            idx        <= idx_n;
            disp_value <= disp_value_n;
            disp_dp    <= disp_dp_n;
            disp_lzb   <= disp_lzb_n;
            pend_full  <= pend_full_n;
            in_ready   <= !pend_full_n;
            seg_out    <= seg_n;
            digit_sel  <= sel_n;
            frame_done <= done_n;
            if (accept) begin
                pend_value <= in_value;
                pend_dp    <= in_dp;
                pend_lzb   <= in_lzb;
            end
        end
    end

endmodule

// File: doc/seg7_scan4.md
# seg7_scan4

Four-digit multiplexed 7-segment scanner, downstream of the hex counter/decoder stage. It accepts a 16-bit hex value, per-digit decimal points and a leading-zero-blank flag through a valid/ready handshake. It time-multiplexes the four digits onto one shared active-low segment bus with inter-digit blanking. New values are swapped in only at frame boundaries, so a displayed number never tears.

## Interface
- DIV_WIDTH, 16: digit slot length is 2^DIV_WIDTH clocks. Legal range 3..24.
- BLANK_CYCLES, 4: all-off clocks at the start of each slot (anti-ghosting). Must satisfy 1 <= BLANK_CYCLES < 2^DIV_WIDTH.
- clk  input  1  single clock; everything is on posedge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  upstream offers a new display word.
- in_ready  output  1  block can accept a word.
- in_value  input  16  hex digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- in_dp  input  4  decimal point per digit; 1 = lit.
- in_lzb  input  1  leading-zero blanking enable.
- seg_out  output  8  active-low segments: bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp.
- digit_sel  output  4  active-low one-hot digit enable; bit n = digit n.
- frame_done  output  1  one-clock pulse at the end of each full 4-digit frame.

## Operation
- State:
  - slot counter cnt (DIV_WIDTH bits)
  - digit index idx (2 bits, order 0,1,2,3,0,…)
  - display register {value, dp, lzb}
  - pending register plus a pending_full flag
- Handshake:
  - in_ready = !pending_full.
  - A transfer happens on any clock where in_valid && in_ready; the word is captured into pending and pending_full is set.
  - in_valid while in_ready = 0 is ignored. Upstream must hold the word.
- Frame boundary is the clock where cnt = all-ones and idx = 3. On that edge:
  - if pending_full was set before the edge, pending is copied to the display register and pending_full is cleared;
  - idx wraps to 0.
- A transfer on the boundary clock while pending is empty goes to pending only. It is displayed at the following boundary.
- Decode (hex, active low, dp bit = 1 before the dp overlay):
  - 0→00000011, 1→10011111, 2→00100101, 3→00001101
  - 4→10011001, 5→01001001, 6→01000001, 7→00011111
  - 8→00000001, 9→00001001, A→00010001, b→11000001
  - c→11100101, d→10000101, E→01100001, F→01110001
- DP overlay: seg_out[0] = !dp[idx]. This applies even to a zero-blanked digit.
- Leading-zero blanking: with lzb set, digit n (n = 3,2,1) shows segments a–g off (bits 7:1 = 1111111) if its nibble and all higher nibbles are 0. Digit 0 is never blanked.
- All outputs come from flops. No combinational path from inputs to seg_out or digit_sel.

## Timing
- Reset values:
  - seg_out 8'hFF, digit_sel 4'hF, frame_done 0, in_ready 1
  - cnt 0, idx 0, display register all 0, pending_full 0
- Reset is asynchronous: asserting rst mid-frame immediately forces all outputs to their reset values and discards any pending word.
- Slot timeline as seen on the outputs, with slot cycle k = 0 .. 2^DIV_WIDTH−1:
  - k < BLANK_CYCLES: digit_sel = 4'hF, seg_out = 8'hFF;
  - otherwise: digit_sel = ~(1<<idx) and seg_out = decoded digit idx of the display register.
- After reset release, the first rising edge is k = 0 of digit 0.
- Frame length is 4·2^DIV_WIDTH clocks. frame_done is high for exactly the last clock of digit 3's slot.
- Handshake timing:
  - in_ready drops the clock after acceptance.
  - in_ready rises the clock after the boundary that consumes pending.
- Accept-to-visible latency is up to 2 frames.
- A display-register update takes effect exactly at k = 0 of digit 0. The segment pattern never changes within a slot.
- cnt and idx wrap modulo their widths. There are no other terminal conditions.

## Test plan
Parameters for all scenarios: DIV_WIDTH=4 (16-clock slots, 64-clock frame), BLANK_CYCLES=2.
- Reset and idle scan: release rst, no input.
  - Each slot: 2 clocks all-off, then 14 clocks of digit_sel 1110,1101,1011,0111 in turn, each with seg_out=00000011.
  - frame_done pulses on clocks 63 and 127.
- Load 16'h1A8F, dp=0100, lzb=0.
  - Next frame shows digit 0=01110001, digit 1=00000001, digit 2=00010000 (A with dp lit), digit 3=10011111.
- Leading-zero blanking: load 16'h0050, lzb=1, dp=0.
  - Digit 3=11111111, digit 2=11111111, digit 1=01001001, digit 0=00000011.
  - Repeat with 16'h0000: only digit 0 is lit (00000011).
- Backpressure: two back-to-back words 16'h1111 then 16'h2222 with in_valid held.
  - in_ready is 0 after the first word until the clock after the next boundary.
  - The second word is accepted only then; displayed value sequence is 1111 then 2222, with no frame mixing digits.
- Boundary coincidence: in_valid on the frame_done clock with pending empty.
  - in_ready falls next clock.
  - The value appears one frame later, not at the immediately following digit 0.
- Async reset mid-slot: assert rst at clock 37 for 1 ns between edges.
  - seg_out=FF, digit_sel=F and in_ready=1 immediately.
  - After release the scan restarts at digit 0 k=0, showing 0000.
